// File: rtl/multi_vc_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : noc_params (package)
// Purpose  : Shared NoC types and default sizing for the multi-VC input buffer.
//            Holds the flit type stored without a VC tag (flit_novc_t) and
//            the default VC count, per-VC depth and on/off hysteresis margin.
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package noc_params;

  localparam int DEF_VC_NUM         = 2;
  localparam int DEF_BUFFER_SIZE    = 8;
  localparam int DEF_ON_OFF_LATENCY = 2;

  localparam int PAYLOAD_W = 14;

  typedef enum logic [1:0] {
    FLIT_HEAD     = 2'd0,
    FLIT_BODY     = 2'd1,
    FLIT_TAIL     = 2'd2,
    FLIT_HEADTAIL = 2'd3
  } flit_label_t;

  // Flit as it sits in the input buffer: the VC field is implied by the
  // queue it lives in, so only the label and payload are stored.
  typedef struct packed {
    flit_label_t          flit_label;
    logic [PAYLOAD_W-1:0] payload;
  } flit_novc_t;

endpackage
`default_nettype wire

// File: rtl/multi_vc_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : multi_vc_buffer_if
// Purpose  : Request/response bundle between the link receiver / allocators
//            and the multi-VC buffer.
// Signals  : data_i, write_i, vc_write_i  - write side (from link receiver)
//            read_i, vc_read_i            - pop side (from allocators)
//            data_o[], is_full_o, is_empty_o, on_off_o, count_o[] - per-VC state
//            error_o                      - sticky protocol error
// Modports : slave (buffer side), master (requester side)
// Revision : 1.0 - initial release
// ============================================================================
interface multi_vc_buffer_if #(
  parameter int VC_NUM      = noc_params::DEF_VC_NUM,
  parameter int BUFFER_SIZE = noc_params::DEF_BUFFER_SIZE
);
  import noc_params::*;

  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  flit_novc_t          data_i;
  logic                write_i;
  logic [VW-1:0]       vc_write_i;
  logic                read_i;
  logic [VW-1:0]       vc_read_i;

  flit_novc_t          data_o     [VC_NUM];
  logic [VC_NUM-1:0]   is_full_o;
  logic [VC_NUM-1:0]   is_empty_o;
  logic [VC_NUM-1:0]   on_off_o;
  logic [CW-1:0]       count_o    [VC_NUM];
  logic                error_o;

  modport slave (
    input  data_i, write_i, vc_write_i, read_i, vc_read_i,
    output data_o, is_full_o, is_empty_o, on_off_o, count_o, error_o
  );

  modport master (
    output data_i, write_i, vc_write_i, read_i, vc_read_i,
    input  data_o, is_full_o, is_empty_o, on_off_o, count_o, error_o
  );

endinterface
`default_nettype wire

// File: rtl/multi_vc_buffer_vc_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vc_fifo_ctrl
// Purpose  : Control state of one virtual-channel circular FIFO: read/write
//            pointers, occupancy count, full/empty flags and on/off flag.
//            Accept strobes arrive already qualified from the top level.
// Ports    : clk, rst (async, active-low)
//            wr_acc_i, rd_acc_i          - accepted write / pop this cycle
//            read_ptr_o, write_ptr_o     - storage pointers
//            count_o, is_full_o, is_empty_o, on_off_o - registered status
// Revision : 1.0 - initial release
// ============================================================================
module vc_fifo_ctrl #(
  parameter  int BUFFER_SIZE    = noc_params::DEF_BUFFER_SIZE,
  parameter  int ON_OFF_LATENCY = noc_params::DEF_ON_OFF_LATENCY,
  localparam int PW             = $clog2(BUFFER_SIZE),
  localparam int CW             = $clog2(BUFFER_SIZE + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_acc_i,
  input  logic          rd_acc_i,
  output logic [PW-1:0] read_ptr_o,
  output logic [PW-1:0] write_ptr_o,
  output logic [CW-1:0] count_o,
  output logic          is_full_o,
  output logic          is_empty_o,
  output logic          on_off_o
);

  localparam logic [PW-1:0] LAST_IDX = PW'(BUFFER_SIZE - 1);
  localparam logic [CW-1:0] FULL_VAL = CW'(BUFFER_SIZE);
  localparam logic [CW-1:0] ON_TH    = CW'(ON_OFF_LATENCY);
  localparam logic [CW-1:0] OFF_TH   = CW'(BUFFER_SIZE - ON_OFF_LATENCY);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, on_off_q, on_off_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    on_off_d = on_off_q;

    // Explicit wrap so depths that are not a power of two work.
    if (rd_acc_i) rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
    if (wr_acc_i) wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;

    if (wr_acc_i && !rd_acc_i)      count_d = count_q + 1'b1;
    else if (rd_acc_i && !wr_acc_i) count_d = count_q - 1'b1;

    // Hysteresis: turn on only when draining below the low mark, turn off
    // only when filling above the high mark; otherwise keep the last decision.
    if (rd_acc_i && !wr_acc_i && (count_d < ON_TH))       on_off_d = 1'b1;
    else if (wr_acc_i && !rd_acc_i && (count_d > OFF_TH)) on_off_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      on_off_q <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == FULL_VAL);
      empty_q  <= (count_d == '0);
      on_off_q <= on_off_d;
    end
  end

  assign read_ptr_o  = rd_ptr_q;
  assign write_ptr_o = wr_ptr_q;
  assign count_o     = count_q;
  assign is_full_o   = full_q;
  assign is_empty_o  = empty_q;
  assign on_off_o    = on_off_q;

endmodule
`default_nettype wire

// File: rtl/multi_vc_buffer.sv
`default_nettype none
// ============================================================================
// Module   : multi_vc_buffer
// Purpose  : Per-input-port flit storage for the VC router: VC_NUM
//            independent circular FIFOs of BUFFER_SIZE flits, each with
//            full/empty/on-off flags and an occupancy count.
// Ports    : clk, rst (async, active-low)
//            bus (multi_vc_buffer_if.slave) - write/pop requests and per-VC
//            head flit, flags, counts and error flag.
// Config   : MULTI_VC_BUFFER_ERR_EN - when defined, error_o is a sticky flag
//            set by a dropped write, a pop of an empty VC or an out-of-range
//            VC index; otherwise error_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module multi_vc_buffer #(
  parameter int VC_NUM         = noc_params::DEF_VC_NUM,
  parameter int BUFFER_SIZE    = noc_params::DEF_BUFFER_SIZE,
  parameter int ON_OFF_LATENCY = noc_params::DEF_ON_OFF_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_vc_buffer_if.slave      bus
);
  import noc_params::*;

  localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int PW = $clog2(BUFFER_SIZE);
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  logic [VC_NUM-1:0] wr_acc, rd_acc;
  logic [VC_NUM-1:0] is_full, is_empty, on_off;
  logic [PW-1:0]     rd_ptr   [VC_NUM];
  logic [PW-1:0]     wr_ptr   [VC_NUM];
  logic [CW-1:0]     count    [VC_NUM];
  flit_novc_t        head     [VC_NUM];

  genvar v;
  generate
    for (v = 0; v < VC_NUM; v++) begin : g_vc
      flit_novc_t mem_q [BUFFER_SIZE];

      // Index compare only matches in-range VCs, so out-of-range requests
      // are never accepted by any FIFO.
      assign rd_acc[v] = bus.read_i && (bus.vc_read_i == VW'(v)) && !is_empty[v];
      // A full VC still takes a write when it is popped in the same cycle.
      assign wr_acc[v] = bus.write_i && (bus.vc_write_i == VW'(v)) &&
                         (!is_full[v] || rd_acc[v]);

      vc_fifo_ctrl #(
        .BUFFER_SIZE    (BUFFER_SIZE),
        .ON_OFF_LATENCY (ON_OFF_LATENCY)
      ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .wr_acc_i    (wr_acc[v]),
        .rd_acc_i    (rd_acc[v]),
        .read_ptr_o  (rd_ptr[v]),
        .write_ptr_o (wr_ptr[v]),
        .count_o     (count[v]),
        .is_full_o   (is_full[v]),
        .is_empty_o  (is_empty[v]),
        .on_off_o    (on_off[v])
      );

      // Storage is deliberately not reset.
      always_ff @(posedge clk) begin
        if (wr_acc[v]) mem_q[wr_ptr[v]] <= bus.data_i;
      end

      assign head[v] = mem_q[rd_ptr[v]];
    end
  endgenerate

  assign bus.data_o     = head;
  assign bus.count_o    = count;
  assign bus.is_full_o  = is_full;
  assign bus.is_empty_o = is_empty;
  assign bus.on_off_o   = on_off;

`ifdef MULTI_VC_BUFFER_ERR_EN
  logic error_q, error_d;

  // Any request that no FIFO accepted is a protocol error: full drop,
  // empty pop or out-of-range index all fall out of the accept vectors.
  always_comb begin
    error_d = error_q;
    if ((bus.write_i && !(|wr_acc)) || (bus.read_i && !(|rd_acc))) error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) error_q <= 1'b0;
    else      error_q <= error_d;
  end

  assign bus.error_o = error_q;
`else
  assign bus.error_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/multi_vc_buffer.md
# multi_vc_buffer

- Per-input-port flit storage for the virtual-channel router: `VC_NUM` independent circular FIFOs, each `BUFFER_SIZE` flits deep.
- Each FIFO has its own full, empty and on/off flow-control flags and an occupancy count.
- Sits between the link receiver, which writes one flit per cycle tagged with a VC, and the VC allocator and switch allocator, which read one flit per cycle from a selected VC.
- Replaces the single-queue buffer with a parametrised bank that supports an on/off threshold and optional error detection.

## Interface
Parameters:
- `VC_NUM`, 2: number of virtual channels (≥1).
- `BUFFER_SIZE`, 8: flits per VC (≥2; need not be a power of two).
- `ON_OFF_LATENCY`, 2: on/off hysteresis margin (1 ≤ value ≤ `BUFFER_SIZE`/2).

Ports (`VW` = `$clog2(VC_NUM)`, min 1; `CW` = `$clog2(BUFFER_SIZE+1)`):
- `clk` in 1: clock; everything is sampled on the rising edge.
- `rst` in 1: reset, asynchronous and active-low. This is fixed: a single clock with asynchronous active-low reset.
- `data_i` in `flit_novc_t`: flit to write.
- `write_i` in 1: write request.
- `vc_write_i` in `VW`: target VC of the write.
- `read_i` in 1: read (pop) request.
- `vc_read_i` in `VW`: VC to pop.
- `data_o[VC_NUM]` out `flit_novc_t`: head flit of each VC (combinational from stored state).
- `is_full_o[VC_NUM]` out 1: VC holds `BUFFER_SIZE` flits.
- `is_empty_o[VC_NUM]` out 1: VC holds 0 flits.
- `on_off_o[VC_NUM]` out 1: 1 means upstream may send on this VC.
- `count_o[VC_NUM]` out `CW`: occupancy of each VC.
- `error_o` out 1: sticky protocol error flag (only with the macro in Configuration).

## Operation
- Per VC state: `read_ptr` and `write_ptr` (range 0..`BUFFER_SIZE`-1), `count`, `is_full`, `is_empty` and `on_off`; all registered.
- Pointer increment wraps: `BUFFER_SIZE`-1 goes to 0.
- Write to VC w is accepted when `write_i` is high and either:
  - `is_full_o[w]`=0, or
  - a read is accepted on the same VC w in the same cycle.
- If accepted, the flit is stored at `write_ptr[w]` and `write_ptr[w]` increments.
- A write to a full VC without a same-VC read is dropped; no state changes.
- Read of VC r is accepted when `read_i`=1 and `is_empty_o[r]`=0; `read_ptr[r]` increments. A read of an empty VC is ignored.
- A read and a write on the same VC with the VC empty: the write is accepted, the read is ignored, and `count` becomes 1. Data never bypasses storage.
- A read and a write on different VCs are independent and both may be accepted.
- Count update: +1 on a write alone, −1 on a read alone, unchanged on both or neither.
  - `is_full_next` = (`count_next`==`BUFFER_SIZE`).
  - `is_empty_next` = (`count_next`==0).
- On/off update, per VC:
  - If the count decreases and `count_next` < `ON_OFF_LATENCY`, `on_off` becomes 1.
  - Else if the count increases and `count_next` > `BUFFER_SIZE`−`ON_OFF_LATENCY`, `on_off` becomes 0.
  - Otherwise `on_off` holds.
- `data_o[v]` = memory[v][`read_ptr[v]`]. The value is don't-care while the VC is empty.
- Out-of-range `vc_write_i` or `vc_read_i` (≥`VC_NUM`): the request is ignored.
- Reset values:
  - Pointers, `count_o`: 0.
  - `is_empty_o`: all 1.
  - `is_full_o`: all 0.
  - `on_off_o`: all 1.
  - `error_o`: 0.
  - Flit storage is not reset.

## Timing
- Flags, count and pointers update on the rising edge that samples the request.
- Write-to-head latency is 1 cycle: a flit written into an empty VC appears on `data_o` after the next edge.
- After a pop, the new head is visible after that edge.
- Flags reflect state after the edge. There is no combinational path from `write_i`/`read_i` to any flag.
- Asserting `rst` mid-operation clears all VCs immediately. Stored flits are lost.

## Configuration
- `MULTI_VC_BUFFER_ERR_EN` defined:
  - `error_o` is set and held until reset on any of: a dropped write to a full VC, a read of an empty VC, or an out-of-range VC index.
- Undefined:
  - `error_o` is tied to 0.
  - No error detection logic is generated.
  - The port list is unchanged.

## Structure
- `noc_params` package holds `flit_novc_t`, `VC_NUM` and `BUFFER_SIZE` defaults, and the `ON_OFF_LATENCY` default.
- Sub-module `vc_fifo_ctrl` contains one VC's pointers, count, flags and on/off logic. It is instantiated `VC_NUM` times with per-VC accept strobes.
- The top level holds the storage array, request decode, accept logic and error logic.

## Test plan
1. Reset, then write flits A, B, C to VC1 on 3 cycles.
   - `count_o[1]`=3, `is_empty_o[1]`=0, `data_o[1]`=A.
   - VC0 stays empty.
2. Fill VC0 with 8 flits, then write again.
   - `is_full_o[0]`=1 and the write is dropped.
   - `on_off_o[0]` went 0 on the edge where `count_o[0]` became 7.
   - With the macro defined, `error_o`=1.
3. VC0 full: simultaneous write X and read on VC0.
   - `count_o[0]` stays 8 and the head advances.
   - After 8 more pops, X is the last flit out.
4. Drain VC0 from 8.
   - `on_off_o[0]` returns to 1 on the edge where the count becomes 1.
   - `is_empty_o[0]`=1 after the 8th pop.
   - Pointers wrap to 0.
5. In the same cycle, write VC1 and read VC0, with VC0 nonempty.
   - Both are accepted and counts move by +1 and −1 respectively.
6. Read and write the same empty VC in one cycle.
   - `count`=1 and the flit appears on `data_o` the next cycle.
   - Asserting `rst` mid-stream restores all reset values.
